// File: rtl/huffman_dc_decoder.sv
`default_nettype none
// =============================================================================
// Module      : huffman_dc_decoder
// Description : Bit-serial JPEG DC decoder with run-time loadable canonical
//               Huffman tables; optional per-slot DC predictor behind the
//               HUFF_DC_PREDICTOR_EN macro.
// Revision    : 1.0 - initial release
// =============================================================================
module huffman_dc_decoder #(
  parameter  int NUM_TABLES   = 2,
  parameter  int MAX_CODE_LEN = 16,
  parameter  int MAX_SIZE     = 11,
  parameter  int NUM_SYMS     = 12,
  localparam int TW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
  localparam int LW = $clog2(MAX_CODE_LEN + 1),
  localparam int DW = MAX_SIZE + 1,
  localparam int SW = $clog2(NUM_SYMS)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
`ifdef HUFF_DC_PREDICTOR_EN
  input  logic                    pred_clr_in,
  output logic [DW:0]             dc_out,
`endif
  input  logic                    start_in,
  input  logic [TW-1:0]           table_sel_in,
  input  logic                    bit_in,
  input  logic                    bit_valid_in,
  output logic                    bit_ready_out,
  input  logic                    lenwr_en_in,
  input  logic [TW-1:0]           lenwr_tbl_in,
  input  logic [LW-1:0]           lenwr_len_in,
  input  logic [MAX_CODE_LEN-1:0] lenwr_mincode_in,
  input  logic [SW:0]             lenwr_count_in,
  input  logic [SW-1:0]           lenwr_valptr_in,
  input  logic                    symwr_en_in,
  input  logic [TW-1:0]           symwr_tbl_in,
  input  logic [SW-1:0]           symwr_addr_in,
  input  logic [3:0]              symwr_data_in,
  output logic                    valid_out,
  input  logic                    out_ready_in,
  output logic [3:0]              size_out,
  output logic [4:0]              codesize_out,
  output logic [DW-1:0]           diff_out,
  output logic                    error_out
);

  localparam int            LIW      = $clog2(MAX_CODE_LEN);
  localparam int            MW       = MAX_SIZE;
  localparam logic [LW-1:0] C_MAXLEN = LW'(MAX_CODE_LEN);
  localparam logic [SW:0]   C_NSYM   = (SW + 1)'(NUM_SYMS);
  localparam logic [3:0]    C_MAXSZ  = 4'(MAX_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_CODE, S_MAG, S_DONE} state_t;

  // Reset contents: slot 1 holds the standard chroma DC table, all others luma.
  function automatic logic [MAX_CODE_LEN-1:0] dflt_mincode(input int t, input int l);
    int v;
    v = 0;
    if (t == 1) begin
      if (l >= 3 && l <= 11) v = (1 << l) - 2;
    end else begin
      if (l == 3) v = 2;
      else if (l >= 4 && l <= 9) v = (1 << l) - 2;
    end
    return MAX_CODE_LEN'(v);
  endfunction

  function automatic logic [SW:0] dflt_count(input int t, input int l);
    int v;
    v = 0;
    if (t == 1) begin
      if (l == 2) v = 3;
      else if (l >= 3 && l <= 11) v = 1;
    end else begin
      if (l == 2) v = 1;
      else if (l == 3) v = 5;
      else if (l >= 4 && l <= 9) v = 1;
    end
    return (SW + 1)'(v);
  endfunction

  function automatic logic [SW-1:0] dflt_valptr(input int t, input int l);
    int v;
    v = 0;
    if (t == 1) begin
      if (l >= 3 && l <= 11) v = l;
    end else begin
      if (l == 3) v = 1;
      else if (l >= 4 && l <= 9) v = l + 2;
    end
    return SW'(v);
  endfunction

  logic [MAX_CODE_LEN-1:0] mincode_q [NUM_TABLES][MAX_CODE_LEN];
  logic [SW:0]             count_q   [NUM_TABLES][MAX_CODE_LEN];
  logic [SW-1:0]           valptr_q  [NUM_TABLES][MAX_CODE_LEN];
  logic [3:0]              store_q   [NUM_TABLES][NUM_SYMS];

  state_t                  state_q, state_d;
  logic [TW-1:0]           tsel_q, tsel_d;
  logic [MAX_CODE_LEN-2:0] code_q, code_d;
  logic [LW-1:0]           len_q, len_d;
  logic [MW-2:0]           mag_q, mag_d;
  logic [3:0]              rem_q, rem_d;
  logic                    valid_q, valid_d;
  logic [3:0]              size_q, size_d;
  logic [4:0]              csize_q, csize_d;
  logic [DW-1:0]           diff_q, diff_d;
  logic                    err_q, err_d;

  logic [LIW-1:0]          w_lw_idx;
  logic                    w_len_ok;

  assign w_lw_idx = LIW'(lenwr_len_in - 1'b1);
  assign w_len_ok = (lenwr_len_in != '0) && (lenwr_len_in <= C_MAXLEN);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int t = 0; t < NUM_TABLES; t++) begin
        for (int l = 0; l < MAX_CODE_LEN; l++) begin
          mincode_q[t][l] <= dflt_mincode(t, l + 1);
          count_q[t][l]   <= dflt_count(t, l + 1);
          valptr_q[t][l]  <= dflt_valptr(t, l + 1);
        end
        for (int a = 0; a < NUM_SYMS; a++) store_q[t][a] <= 4'(a);
      end
    end else begin
      if (lenwr_en_in && w_len_ok) begin
        mincode_q[lenwr_tbl_in][w_lw_idx] <= lenwr_mincode_in;
        count_q[lenwr_tbl_in][w_lw_idx]   <= lenwr_count_in;
        valptr_q[lenwr_tbl_in][w_lw_idx]  <= lenwr_valptr_in;
      end
      if (symwr_en_in && ({1'b0, symwr_addr_in} < C_NSYM))
        store_q[symwr_tbl_in][symwr_addr_in] <= symwr_data_in;
    end
  end

  // Canonical match against the length entry for the bit being accepted now.
  logic [MAX_CODE_LEN-1:0] w_code_nx, w_off;
  logic [LW-1:0]           w_len_nx;
  logic [LIW-1:0]          w_lidx;
  logic [SW:0]             w_cnt, w_saddr;
  logic                    w_match;
  logic [3:0]              w_sym;
  logic [MW-1:0]           w_mag_nx;
  logic [DW-1:0]           w_magx, w_mask, w_diff;
  logic                    w_msb;

  assign w_code_nx = {code_q, bit_in};
  assign w_len_nx  = len_q + 1'b1;
  assign w_lidx    = LIW'(len_q);
  assign w_off     = w_code_nx - mincode_q[tsel_q][w_lidx];
  assign w_cnt     = count_q[tsel_q][w_lidx];
  assign w_match   = (w_cnt != '0) &&
                     (w_off < {{(MAX_CODE_LEN - SW - 1){1'b0}}, w_cnt});
  assign w_saddr   = (SW + 1)'(valptr_q[tsel_q][w_lidx]) + w_off[SW:0];
  assign w_sym     = (w_saddr < C_NSYM) ? store_q[tsel_q][w_saddr[SW-1:0]] : 4'd0;

  // EXTEND: a clear top magnitude bit means the value is negative.
  assign w_mag_nx  = {mag_q, bit_in};
  assign w_magx    = {1'b0, w_mag_nx};
  assign w_mask    = (DW'(1) << size_q) - DW'(1);
  assign w_msb     = |(w_magx & (w_mask ^ (w_mask >> 1)));
  assign w_diff    = w_msb ? w_magx : (w_magx - w_mask);

  always_comb begin
    state_d = state_q;
    tsel_d  = tsel_q;
    code_d  = code_q;
    len_d   = len_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    size_d  = size_q;
    csize_d = csize_q;
    diff_d  = diff_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_CODE;
          tsel_d  = table_sel_in;
          code_d  = '0;
          len_d   = '0;
          mag_d   = '0;
          rem_d   = '0;
        end
      end
      S_CODE: begin
        if (bit_valid_in) begin
          code_d = w_code_nx[MAX_CODE_LEN-2:0];
          len_d  = w_len_nx;
          if (w_match) begin
            csize_d = 5'(w_len_nx);
            size_d  = w_sym;
            diff_d  = '0;
            err_d   = 1'b0;
            if (w_sym == 4'd0) begin
              state_d = S_DONE;
              valid_d = 1'b1;
            end else if (w_sym > C_MAXSZ) begin
              state_d = S_DONE;
              valid_d = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = S_MAG;
              rem_d   = w_sym;
            end
          end else if (w_len_nx == C_MAXLEN) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            err_d   = 1'b1;
            size_d  = 4'd0;
            csize_d = 5'(MAX_CODE_LEN);
            diff_d  = '0;
          end
        end
      end
      S_MAG: begin
        if (bit_valid_in) begin
          mag_d = w_mag_nx[MW-2:0];
          rem_d = rem_q - 1'b1;
          if (rem_q == 4'd1) begin
            diff_d  = w_diff;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready_in) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      tsel_q  <= '0;
      code_q  <= '0;
      len_q   <= '0;
      mag_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      size_q  <= '0;
      csize_q <= '0;
      diff_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tsel_q  <= tsel_d;
      code_q  <= code_d;
      len_q   <= len_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      size_q  <= size_d;
      csize_q <= csize_d;
      diff_q  <= diff_d;
      err_q   <= err_d;
    end
  end

  assign bit_ready_out = (state_q == S_CODE) || (state_q == S_MAG);
  assign valid_out     = valid_q;
  assign size_out      = size_q;
  assign codesize_out  = csize_q;
  assign diff_out      = diff_q;
  assign error_out     = err_q;

`ifdef HUFF_DC_PREDICTOR_EN
  logic [DW:0] pred_q [NUM_TABLES];

  assign dc_out = pred_q[tsel_q] + {diff_q[DW-1], diff_q};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int t = 0; t < NUM_TABLES; t++) pred_q[t] <= '0;
    end else if (pred_clr_in) begin
      for (int t = 0; t < NUM_TABLES; t++) pred_q[t] <= '0;
    end else if ((state_q == S_DONE) && out_ready_in && !err_q) begin
      pred_q[tsel_q] <= dc_out;
    end
  end
`endif

endmodule
`default_nettype wire
